// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Brief    : Shared encodings, round counts, FSM state type and the
//             mode-to-round-count helper for the AES self-test controller.
//  Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Key-size mode encodings as driven by the board switches
  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;
  localparam logic [1:0] MODE_INV = 2'b11;

  // Round counts per key size
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENC_WAIT = 2'd1,
    ST_DEC_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Round count for a key-size mode; the invalid mode maps to 0
  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    logic [3:0] nr;
    case (mode)
      MODE_128: nr = NR_128;
      MODE_192: nr = NR_192;
      MODE_256: nr = NR_256;
      default:  nr = 4'd0;
    endcase
    return nr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_lat_counter
//  Brief    : Cycle counter shared by the cipher and decipher wait phases.
//             Clear has priority over count; term flags the last cycle of a
//             phase, i.e. cnt == nr + LAT_EXTRA - 1.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_lat_counter #(
  parameter int LAT_EXTRA = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       en,
  input  logic [3:0] nr,
  output logic       term
);

  logic [4:0] cnt;
  logic [4:0] limit;

  // Terminal count of the current phase, computed in the 5-bit counter domain
  always_comb begin
    limit = {1'b0, nr} + 5'(LAT_EXTRA) - 5'd1;
    term  = (cnt == limit);
  end

  // Count cycles of the active phase; clear reloads zero for the next phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 5'd0;
    end else if (clear) begin
      cnt <= 5'd0;
    end else if (en) begin
      cnt <= cnt + 5'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_selftest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_selftest_ctrl
//  Brief    : Sequencer for the AES encrypt/decrypt self-test. Latches the
//             key-size mode on start, waits out the cipher latency, captures
//             and checks the ciphertext, feeds it to the decipher, waits
//             again, then captures and checks the recovered plaintext.
//             Datapath muxing stays outside; this block only drives sel.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_selftest_ctrl
  import aes_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int LAT_EXTRA = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] enc_data,
  input  logic [DATA_W-1:0] dec_data,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] plain,
  output logic [1:0]        sel,
  output logic [3:0]        nr,
  output logic              dec_en,
  output logic [DATA_W-1:0] dec_in,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              enc_ok,
  output logic              dec_ok,
  output logic              mode_err
);

  state_t state;
  logic   waiting;
  logic   cnt_clear;
  logic   term;

  // Counter control: runs only in the wait phases and restarts at each phase end
  always_comb begin
    waiting   = (state == ST_ENC_WAIT) || (state == ST_DEC_WAIT);
    cnt_clear = (state == ST_IDLE) || (waiting && term);
  end

  aes_lat_counter #(
    .LAT_EXTRA (LAT_EXTRA)
  ) u_lat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .en    (waiting),
    .nr    (nr),
    .term  (term)
  );

  // Sequencing FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel      <= 2'b00;
      nr       <= 4'd0;
      dec_en   <= 1'b0;
      dec_in   <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      enc_ok   <= 1'b0;
      dec_ok   <= 1'b0;
      mode_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mode == MODE_INV) begin
              // Reject without touching sel/nr or the datapath
              mode_err <= 1'b1;
              enc_ok   <= 1'b0;
              dec_ok   <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              sel      <= mode;
              nr       <= nr_of(mode);
              enc_ok   <= 1'b0;
              dec_ok   <= 1'b0;
              mode_err <= 1'b0;
              busy     <= 1'b1;
              state    <= ST_ENC_WAIT;
            end
          end
        end
        ST_ENC_WAIT: begin
          if (term) begin
            dec_in <= enc_data;
            enc_ok <= (enc_data == expected);
            dec_en <= 1'b1;
            state  <= ST_DEC_WAIT;
          end
        end
        ST_DEC_WAIT: begin
          if (term) begin
            result <= dec_data;
            dec_ok <= (dec_data == plain);
            dec_en <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_selftest_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_selftest_ctrl
//  Brief    : Self-checking bench for aes_selftest_ctrl. A cycle-exact
//             datapath model presents valid cipher/decipher outputs only on
//             the capture edge; expectations are queued per run and checked
//             on the done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_selftest_ctrl;

  localparam int DW  = 128;
  localparam int LAT = 2;

  localparam logic [DW-1:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DW-1:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [DW-1:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] enc_data = '0;
  logic [DW-1:0] dec_data = '0;
  logic [DW-1:0] expected = '0;
  logic [DW-1:0] plain = PT;
  logic [1:0]    sel;
  logic [3:0]    nr;
  logic          dec_en;
  logic [DW-1:0] dec_in;
  logic [DW-1:0] result;
  logic          busy;
  logic          done;
  logic          enc_ok;
  logic          dec_ok;
  logic          mode_err;

  aes_selftest_ctrl #(
    .DATA_W    (DW),
    .LAT_EXTRA (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .enc_data (enc_data),
    .dec_data (dec_data),
    .expected (expected),
    .plain    (plain),
    .sel      (sel),
    .nr       (nr),
    .dec_en   (dec_en),
    .dec_in   (dec_in),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .enc_ok   (enc_ok),
    .dec_ok   (dec_ok),
    .mode_err (mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            done_n;
    logic [1:0]    sel;
    logic [3:0]    nr;
    logic          enc_ok;
    logic          dec_ok;
    logic          mode_err;
    logic [DW-1:0] result;
    logic [DW-1:0] dec_in;
    bit            chk_data;
    int            act_cycles;
  } exp_t;

  exp_t          sb[$];
  int            tests = 0;
  int            fails = 0;
  int            ncyc = 0;
  int            run_n = 0;
  int            run_t = 0;
  bit            run_active = 1'b0;
  logic [DW-1:0] run_ct = '0;
  int            dec_en_cnt = 0;
  int            busy_cnt = 0;
  logic [1:0]    last_sel = 2'b00;
  logic [3:0]    last_nr = 4'd0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_ct(input logic [1:0] m);
    case (m)
      2'b00:   return CT_128;
      2'b01:   return CT_192;
      2'b10:   return CT_256;
      default: return '0;
    endcase
  endfunction

  function automatic int rounds(input logic [1:0] m);
    case (m)
      2'b00:   return 10;
      2'b01:   return 12;
      2'b10:   return 14;
      default: return 0;
    endcase
  endfunction

  function automatic logic [DW-1:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor/scoreboard plus datapath model; valid data only on capture cycles
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!rst_n) begin
      dec_en_cnt = 0;
      busy_cnt   = 0;
    end else begin
      if (dec_en) dec_en_cnt++;
      if (busy)   busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_time", ncyc, e.done_n);
          chk("sel", sel, e.sel);
          chk("nr", nr, e.nr);
          chk("enc_ok", enc_ok, e.enc_ok);
          chk("dec_ok", dec_ok, e.dec_ok);
          chk("mode_err", mode_err, e.mode_err);
          chk("busy_in_done", busy, 0);
          chk("dec_en_cycles", dec_en_cnt, e.act_cycles);
          chk("busy_cycles", busy_cnt, 2 * e.act_cycles);
          if (e.chk_data) begin
            chk("result", result, e.result);
            chk("dec_in", dec_in, e.dec_in);
          end
        end
        dec_en_cnt = 0;
        busy_cnt   = 0;
      end
    end
    enc_data = (run_active && ncyc == run_n + 1 + run_t) ? run_ct : junk();
    dec_data = (run_active && ncyc == run_n + 1 + 2 * run_t) ? PT : junk();
  end

  task automatic run(input logic [1:0] m, input bit corrupt, input bit disturb);
    exp_t e;
    bit   valid;
    valid = (m != 2'b11);
    @(posedge clk); #1;
    mode       = m;
    expected   = ref_ct(m);
    plain      = PT;
    run_n      = ncyc;
    run_t      = valid ? rounds(m) + LAT : 0;
    run_ct     = ref_ct(m) ^ {{(DW-1){1'b0}}, corrupt};
    run_active = valid;
    if (valid) begin
      last_sel = m;
      last_nr  = 4'(rounds(m));
    end
    e.done_n     = run_n + 2 + 2 * run_t;
    e.sel        = last_sel;
    e.nr         = last_nr;
    e.enc_ok     = valid && !corrupt;
    e.dec_ok     = valid;
    e.mode_err   = !valid;
    e.result     = PT;
    e.dec_in     = run_ct;
    e.chk_data   = valid;
    e.act_cycles = run_t;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (disturb) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; mode = 2'b10;
      @(posedge clk);
      #1 start = 1'b0; mode = 2'b00;
      repeat (2) @(posedge clk);
      #1 start = 1'b1; mode = 2'b10;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      chk("run_timeout", sb.size(), 0);
      sb.delete();
    end
    run_active = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_sel", sel, 0);
    chk("rst_nr", nr, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_dec_in", dec_in, 0);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {enc_ok, dec_ok, mode_err}, 0);
    @(posedge clk); #3 rst_n = 1'b1;

    run(2'b00, 1'b0, 1'b0);
    run(2'b10, 1'b0, 1'b0);
    run(2'b11, 1'b0, 1'b0);
    run(2'b01, 1'b1, 1'b0);
    run(2'b00, 1'b0, 1'b1);

    // Abort a 128-bit run while the decipher is running
    @(posedge clk); #1;
    mode       = 2'b00;
    expected   = CT_128;
    run_n      = ncyc;
    run_t      = 12;
    run_ct     = CT_128;
    run_active = 1'b1;
    start      = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (16) @(posedge clk);
    #3;
    chk("pre_reset_dec_en", dec_en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_sel_nr", {sel, nr}, 0);
    chk("abort_dec_in", dec_in, 0);
    chk("abort_result", result, 0);
    chk("abort_ctrl", {dec_en, busy, done}, 0);
    chk("abort_flags", {enc_ok, dec_ok, mode_err}, 0);
    run_active = 1'b0;
    last_sel   = 2'b00;
    last_nr    = 4'd0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    run(2'b00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
